// File: rtl/micro_sequencer.sv
// Writable-control-store microprogram sequencer: one microinstruction per clock,
// with dispatch tables, conditional branch and a small call/return stack.
module micro_sequencer #(
  parameter int UADDR_W     = 6,
  parameter int CTRL_W      = 16,
  parameter int OP_W        = 6,
  parameter int COND_W      = 4,
  parameter int STACK_DEPTH = 2,
  localparam int CSEL_W     = $clog2(COND_W),
  localparam int MW         = CTRL_W + 3 + CSEL_W + UADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [OP_W-1:0]     op_code,
  input  logic [COND_W-1:0]   cond,
  input  logic                cs_we,
  input  logic [UADDR_W-1:0]  cs_waddr,
  input  logic [MW-1:0]       cs_wdata,
  input  logic                dt_we,
  input  logic                dt_sel,
  input  logic [OP_W-1:0]     dt_waddr,
  input  logic [UADDR_W-1:0]  dt_wdata,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [UADDR_W-1:0]  uaddr,
  output logic                stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  // Stack storage is rounded up so the sp register indexes it without truncation.
  localparam int STK_N = 2 ** SP_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    SEQ_NEXT   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DISP1  = 3'd2,
    SEQ_DISP2  = 3'd3,
    SEQ_JUMP   = 3'd4,
    SEQ_BRANCH = 3'd5,
    SEQ_CALL   = 3'd6,
    SEQ_RET    = 3'd7
  } seq_e;

  logic [MW-1:0]      r_cs    [2**UADDR_W];
  logic [UADDR_W-1:0] r_dt1   [2**OP_W];
  logic [UADDR_W-1:0] r_dt2   [2**OP_W];
  logic [UADDR_W-1:0] r_stack [STK_N];

  logic [UADDR_W-1:0] r_upc;
  logic [SP_W-1:0]    r_sp;
  logic               r_err;

  logic [MW-1:0]      w_mw;
  seq_e               w_seq;
  logic [CSEL_W-1:0]  w_csel;
  logic [UADDR_W-1:0] w_naddr;
  logic [UADDR_W-1:0] w_inc;
  logic [UADDR_W-1:0] w_upc_next;
  logic [SP_W-1:0]    w_sp_next;
  logic               w_err_next;
  logic               w_push;

  // Asynchronous read keeps ctrl in the same cycle as uPC.
  assign w_mw    = r_cs[r_upc];
  assign w_seq   = seq_e'(w_mw[UADDR_W+CSEL_W +: 3]);
  assign w_csel  = w_mw[UADDR_W +: CSEL_W];
  assign w_naddr = w_mw[UADDR_W-1:0];
  assign w_inc   = r_upc + UADDR_W'(1);

  always_comb begin
    w_upc_next = r_upc;
    w_sp_next  = r_sp;
    w_err_next = r_err;
    w_push     = 1'b0;
    if (!stall) begin
      case (w_seq)
        SEQ_NEXT:   w_upc_next = w_inc;
        SEQ_FETCH:  w_upc_next = '0;
        SEQ_DISP1:  w_upc_next = r_dt1[op_code];
        SEQ_DISP2:  w_upc_next = r_dt2[op_code];
        SEQ_JUMP:   w_upc_next = w_naddr;
        SEQ_BRANCH: w_upc_next = cond[w_csel] ? w_naddr : w_inc;
        SEQ_CALL: begin
          if (r_sp == SP_FULL) begin
            w_upc_next = '0;
            w_err_next = 1'b1;
          end else begin
            w_push     = 1'b1;
            w_sp_next  = r_sp + SP_W'(1);
            w_upc_next = w_naddr;
          end
        end
        SEQ_RET: begin
          if (r_sp == '0) begin
            w_upc_next = '0;
            w_err_next = 1'b1;
          end else begin
            w_sp_next  = r_sp - SP_W'(1);
            w_upc_next = r_stack[r_sp - SP_W'(1)];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upc <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_upc <= w_upc_next;
      r_sp  <= w_sp_next;
      r_err <= w_err_next;
    end
  end

  // Stack contents need no reset: clearing sp is enough to discard them.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp] <= w_inc;
  end

  always_ff @(posedge clk) begin
    if (cs_we) r_cs[cs_waddr] <= cs_wdata;
    if (dt_we && !dt_sel) r_dt1[dt_waddr] <= dt_wdata;
    if (dt_we && dt_sel)  r_dt2[dt_waddr] <= dt_wdata;
  end

  assign ctrl      = (rst_n && !stall) ? w_mw[MW-1 -: CTRL_W] : '0;
  assign uaddr     = r_upc;
  assign stack_err = r_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a default-size instance checked every cycle against
// a behavioural model, plus a 2-bit-address instance for the wrap-around run.
module tb_micro_sequencer;

  localparam int MW    = 27;
  localparam int SMW   = 23;
  localparam int DEPTH = 2;
  localparam int NEXT = 0, FETCH = 1, DISP1 = 2, DISP2 = 3;
  localparam int JUMP = 4, BRANCH = 5, CALL = 6, RET = 7;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic [5:0]    op_code;
  logic [3:0]    cond;
  logic          cs_we;
  logic [5:0]    cs_waddr;
  logic [MW-1:0] cs_wdata;
  logic          dt_we;
  logic          dt_sel;
  logic [5:0]    dt_waddr;
  logic [5:0]    dt_wdata;
  logic [15:0]   ctrl;
  logic [5:0]    uaddr;
  logic          stack_err;

  logic           s_stall;
  logic           s_cs_we;
  logic [1:0]     s_cs_waddr;
  logic [SMW-1:0] s_cs_wdata;
  logic [15:0]    s_ctrl;
  logic [1:0]     s_uaddr;
  logic           s_err;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  micro_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .op_code(op_code), .cond(cond),
    .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
    .dt_we(dt_we), .dt_sel(dt_sel), .dt_waddr(dt_waddr), .dt_wdata(dt_wdata),
    .ctrl(ctrl), .uaddr(uaddr), .stack_err(stack_err)
  );

  micro_sequencer #(.UADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .stall(s_stall), .op_code(op_code), .cond(cond),
    .cs_we(s_cs_we), .cs_waddr(s_cs_waddr), .cs_wdata(s_cs_wdata),
    .dt_we(1'b0), .dt_sel(1'b0), .dt_waddr(dt_waddr), .dt_wdata(2'b00),
    .ctrl(s_ctrl), .uaddr(s_uaddr), .stack_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the default instance.
  logic [MW-1:0] m_cs  [64];
  logic [5:0]    m_dt1 [64];
  logic [5:0]    m_dt2 [64];
  int m_stk [DEPTH];
  int m_upc = 0;
  int m_sp  = 0;
  logic m_err = 1'b0;
  int m_nxt, m_inc;
  logic m_push, m_pop, m_eset;
  logic [MW-1:0] m_w;

  always_comb begin
    m_w    = m_cs[m_upc];
    m_inc  = (m_upc + 1) % 64;
    m_nxt  = m_inc;
    m_push = 1'b0;
    m_pop  = 1'b0;
    m_eset = 1'b0;
    case (int'(m_w[10:8]))
      NEXT:   m_nxt = m_inc;
      FETCH:  m_nxt = 0;
      DISP1:  m_nxt = int'(m_dt1[op_code]);
      DISP2:  m_nxt = int'(m_dt2[op_code]);
      JUMP:   m_nxt = int'(m_w[5:0]);
      BRANCH: m_nxt = cond[m_w[7:6]] ? int'(m_w[5:0]) : m_inc;
      CALL: begin
        if (m_sp >= DEPTH) begin
          m_nxt = 0; m_eset = 1'b1;
        end else begin
          m_nxt = int'(m_w[5:0]); m_push = 1'b1;
        end
      end
      default: begin
        if (m_sp == 0) begin
          m_nxt = 0; m_eset = 1'b1;
        end else begin
          m_nxt = m_stk[m_sp-1]; m_pop = 1'b1;
        end
      end
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_upc <= 0;
      m_sp  <= 0;
      m_err <= 1'b0;
    end else if (!stall) begin
      m_upc <= m_nxt;
      if (m_push) begin
        m_stk[m_sp] <= m_inc;
        m_sp <= m_sp + 1;
      end
      if (m_pop) m_sp <= m_sp - 1;
      if (m_eset) m_err <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (cs_we) m_cs[cs_waddr] <= cs_wdata;
    if (dt_we) begin
      if (dt_sel) m_dt2[dt_waddr] <= dt_wdata;
      else        m_dt1[dt_waddr] <= dt_wdata;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_ctrl();
    return (!rst_n || stall) ? 0 : int'(m_cs[m_upc][26:11]);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_uaddr", int'(uaddr), m_upc);
      chk("model_ctrl", int'(ctrl), model_ctrl());
      chk("model_stack_err", int'(stack_err), int'(m_err));
    end
  end

  task automatic run();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cs(input int a, input int c, input int sq, input int sel, input int na);
    cs_we    = 1'b1;
    cs_waddr = a[5:0];
    cs_wdata = {c[15:0], sq[2:0], sel[1:0], na[5:0]};
    run();
    cs_we = 1'b0;
  endtask

  task automatic wr_dt(input int sel, input int a, input int d);
    dt_we    = 1'b1;
    dt_sel   = sel[0];
    dt_waddr = a[5:0];
    dt_wdata = d[5:0];
    run();
    dt_we = 1'b0;
  endtask

  int exp_seq [6] = '{1, 8, 16, 9, 2, 0};

  initial begin
    rst_n = 1'b0; stall = 1'b1; s_stall = 1'b1;
    op_code = '0; cond = '0;
    cs_we = 1'b0; cs_waddr = '0; cs_wdata = '0;
    dt_we = 1'b0; dt_sel = 1'b0; dt_waddr = '0; dt_wdata = '0;
    s_cs_we = 1'b0; s_cs_waddr = '0; s_cs_wdata = '0;
    repeat (2) run();
    chk("reset_uaddr", int'(uaddr), 0);
    chk("reset_ctrl", int'(ctrl), 0);
    chk("reset_stack_err", int'(stack_err), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Sequential run with wrap on the 2-bit instance.
    for (int i = 0; i < 4; i++) begin
      int c;
      c = i + 1;
      s_cs_we = 1'b1;
      s_cs_waddr = i[1:0];
      s_cs_wdata = {c[15:0], 3'd0, 2'd0, 2'd0};
      run();
    end
    s_cs_we = 1'b0;
    s_stall = 1'b0;
    #1;
    chk("wrap_uaddr0", int'(s_uaddr), 0);
    chk("wrap_ctrl0", int'(s_ctrl), 1);
    for (int k = 1; k <= 5; k++) begin
      run();
      chk("wrap_uaddr", int'(s_uaddr), k % 4);
      chk("wrap_ctrl", int'(s_ctrl), (k % 4) + 1);
    end
    s_stall = 1'b1;
    #1;
    chk("wrap_stall_ctrl", int'(s_ctrl), 0);
    run();
    chk("wrap_stall_uaddr", int'(s_uaddr), 1);

    // Fill both stores, exercising simultaneous cs and dt writes.
    for (int i = 0; i < 64; i++) begin
      cs_we = 1'b1; cs_waddr = i[5:0]; cs_wdata = {16'h0, 3'(FETCH), 2'd0, 6'd0};
      dt_we = 1'b1; dt_sel = 1'b0; dt_waddr = i[5:0]; dt_wdata = '0;
      run();
    end
    cs_we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dt_we = 1'b1; dt_sel = 1'b1; dt_waddr = i[5:0]; dt_wdata = '0;
      run();
    end
    dt_we = 1'b0;

    // Dispatch through both tables, with a stall in the middle.
    wr_cs(0, 'h0A01, NEXT, 0, 0);
    wr_cs(1, 'h0A02, DISP1, 0, 0);
    wr_cs(5, 'h0A05, DISP2, 0, 0);
    wr_cs(9, 'h0A09, FETCH, 0, 0);
    wr_dt(0, 'h23, 5);
    wr_dt(1, 'h23, 9);
    op_code = 6'h23;
    stall = 1'b0;
    #1;
    chk("disp_ctrl0", int'(ctrl), 'h0A01);
    run(); chk("disp_uaddr1", int'(uaddr), 1);
    run(); chk("disp_uaddr5", int'(uaddr), 5);
    stall = 1'b1;
    #1;
    chk("stall_ctrl", int'(ctrl), 0);
    run(); chk("stall_uaddr", int'(uaddr), 5);
    stall = 1'b0;
    run(); chk("disp_uaddr9", int'(uaddr), 9);
    run(); chk("disp_uaddr_fetch", int'(uaddr), 0);
    stall = 1'b1;

    // Branch taken and not taken on cond[1].
    wr_cs(0, 'h0B00, JUMP, 0, 2);
    wr_cs(2, 'h0B02, BRANCH, 1, 12);
    wr_cs(12, 'h0B0C, FETCH, 0, 0);
    wr_cs(3, 'h0B03, FETCH, 0, 0);
    cond = 4'b0010;
    stall = 1'b0;
    run(); chk("br_uaddr2", int'(uaddr), 2);
    run(); chk("br_taken", int'(uaddr), 12);
    run();
    cond = 4'b1101;
    run(); chk("br_uaddr2b", int'(uaddr), 2);
    run(); chk("br_not_taken", int'(uaddr), 3);
    run();
    stall = 1'b1;

    // Nested call/return.
    wr_cs(0, 'h0C00, JUMP, 0, 1);
    wr_cs(1, 'h0C01, CALL, 0, 8);
    wr_cs(8, 'h0C08, CALL, 0, 16);
    wr_cs(16, 'h0C10, RET, 0, 0);
    wr_cs(9, 'h0C09, RET, 0, 0);
    wr_cs(2, 'h0C02, FETCH, 0, 0);
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run();
      chk("call_ret_uaddr", int'(uaddr), exp_seq[i]);
    end
    chk("call_ret_err", int'(stack_err), 0);
    stall = 1'b1;

    // Third nested call overflows.
    wr_cs(0, 'h0C20, CALL, 0, 20);
    wr_cs(20, 'h0C21, CALL, 0, 24);
    wr_cs(24, 'h0C22, CALL, 0, 28);
    stall = 1'b0;
    run(); chk("ovf_uaddr20", int'(uaddr), 20);
    run(); chk("ovf_uaddr24", int'(uaddr), 24);
    run(); chk("ovf_uaddr", int'(uaddr), 0);
    chk("ovf_err", int'(stack_err), 1);
    stall = 1'b1;

    // Reset clears the sticky error.
    #2 rst_n = 1'b0;
    #1 chk("rst_err_clear", int'(stack_err), 0);
    rst_n = 1'b1;

    // Reset mid-call discards the stack, so the later RET underflows.
    wr_cs(0, 'h0C30, CALL, 0, 30);
    wr_cs(30, 'h0C31, RET, 0, 0);
    stall = 1'b0;
    run(); chk("midcall_uaddr30", int'(uaddr), 30);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_uaddr", int'(uaddr), 0);
    chk("midrst_ctrl", int'(ctrl), 0);
    chk("midrst_err", int'(stack_err), 0);
    stall = 1'b1;
    rst_n = 1'b1;
    wr_cs(0, 'h0C40, JUMP, 0, 30);
    stall = 1'b0;
    run(); chk("udf_uaddr30", int'(uaddr), 30);
    run(); chk("udf_uaddr", int'(uaddr), 0);
    chk("udf_err", int'(stack_err), 1);
    stall = 1'b1;

    // Write to the executing word: old word acts now, new one next visit.
    wr_cs(0, 'h0D00, JUMP, 0, 4);
    wr_cs(4, 'h0D04, JUMP, 0, 6);
    wr_cs(6, 'h0D06, DISP1, 0, 0);
    stall = 1'b0;
    run(); chk("wx_uaddr4", int'(uaddr), 4);
    cs_we = 1'b1; cs_waddr = 6'd4; cs_wdata = {16'h0DEE, 3'(NEXT), 2'd0, 6'd0};
    dt_we = 1'b1; dt_sel = 1'b0; dt_waddr = 6'h23; dt_wdata = 6'd7;
    #1;
    chk("wx_old_ctrl", int'(ctrl), 'h0D04);
    run();
    cs_we = 1'b0; dt_we = 1'b0;
    chk("wx_old_naddr", int'(uaddr), 6);
    run(); chk("wx_new_dt1", int'(uaddr), 7);
    run(); chk("wx_uaddr0", int'(uaddr), 0);
    run(); chk("wx_uaddr4b", int'(uaddr), 4);
    chk("wx_new_ctrl", int'(ctrl), 'h0DEE);
    run(); chk("wx_new_seq", int'(uaddr), 5);
    stall = 1'b1;
    repeat (2) run();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogram sequencer for the multi-cycle CPU control path, replacing the fixed-ROM, fixed-width microcoded control unit. It holds a writable control store and two writable dispatch tables, and steps one microinstruction per clock. It supports sequential, dispatch, jump, conditional-branch and call/return sequencing. It drives the datapath control bits directly and supports stalling.

## Interface
Parameters:
- UADDR_W, 6: microaddress width; the control store has 2^UADDR_W words.
- CTRL_W, 16: control field width, driven out on ctrl.
- OP_W, 6: opcode width; each dispatch table has 2^OP_W entries.
- COND_W, 4: number of condition inputs; must be a power of 2, with CSEL_W = clog2(COND_W).
- STACK_DEPTH, 2: depth of the return-address stack, minimum 1.

Microword width is MW = CTRL_W + 3 + CSEL_W + UADDR_W. The microword is laid out MSB to LSB as {ctrl, seq[2:0], csel, naddr}.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold the microPC and force ctrl to 0.
- op_code  in  OP_W  opcode from the IR, used as the dispatch index.
- cond  in  COND_W  datapath status flags (zero, sign, ...).
- cs_we  in  1  control store write strobe.
- cs_waddr  in  UADDR_W  control store write address.
- cs_wdata  in  MW  control store write data.
- dt_we  in  1  dispatch table write strobe.
- dt_sel  in  1  selects the table: 0 = table 1, 1 = table 2.
- dt_waddr  in  OP_W  dispatch table write index.
- dt_wdata  in  UADDR_W  dispatch table write data.
- ctrl  out  CTRL_W  datapath control bits.
- uaddr  out  UADDR_W  current microPC.
- stack_err  out  1  sticky flag for stack overflow or underflow.

## Operation
- The microPC register is uPC. The current microword is mw = cs[uPC], read combinationally.
- ctrl = mw.ctrl, except that ctrl = 0 while stall = 1 or rst_n = 0.
- uaddr = uPC.
- Next-uPC is selected by mw.seq:
  - 0 NEXT: uPC+1, wrapping from 2^UADDR_W-1 to 0.
  - 1 FETCH: 0.
  - 2 DISP1: dt1[op_code].
  - 3 DISP2: dt2[op_code].
  - 4 JUMP: naddr.
  - 5 BRANCH: naddr if cond[csel] = 1, else uPC+1.
  - 6 CALL: push uPC+1 (wrapped), then naddr.
  - 7 RET: pop the stack top.
- Stack:
  - sp counts 0..STACK_DEPTH.
  - CALL with sp = STACK_DEPTH: no push, next-uPC = 0, stack_err is set.
  - RET with sp = 0: next-uPC = 0, stack_err is set.
  - stack_err stays set until reset.
- Stall: when stall = 1, uPC, sp, stack contents and stack_err all hold. Sequencing effects of the current word (push, pop, error) are suppressed.
- Writes:
  - cs_we and dt_we write on the rising edge and are independent of stall.
  - Both may be asserted in the same cycle.
  - A write to the word currently addressed does not affect this cycle's ctrl or next-uPC. The new contents are visible from the next cycle.
- Contents at power-up: the control store and dispatch tables are not reset. Software or the bench loads them, holding stall = 1, before releasing stall.

## Timing
- Reset (rst_n = 0, asynchronous):
  - uPC = 0, uaddr = 0, sp = 0, stack_err = 0, ctrl = 0 immediately.
  - Stored memories are unchanged.
  - Reset asserted mid-program, or mid-call, discards the stack.
- On deassertion, the first rising edge with stall = 0 executes cs[0].
- Each unstalled cycle executes exactly one microinstruction. The next-uPC is registered on the rising edge.
- ctrl is valid combinationally in the same cycle that uPC is presented. There is no extra pipeline stage.
- Dispatch uses op_code sampled at the edge that ends the dispatching cycle. op_code must be stable before that edge.
- BRANCH samples cond[csel] at that same edge.
- CALL immediately followed by RET returns in 2 cycles total. A push and a pop never occur in the same cycle.

## Test plan
- **Sequential run with wrap.** Load NEXT words 0..3 with ctrl = 16'h0001..16'h0004. With UADDR_W = 2, release stall. Required: ctrl sequence 1, 2, 3, 4, 1 and uaddr 0, 1, 2, 3, 0. Then assert stall: ctrl = 0 and uaddr frozen.
- **Dispatch.** Set dt1[6'h23] = 5 and dt2[6'h23] = 9. cs[1] = DISP1 and cs[5] = DISP2. With op_code = 6'h23, run from 0 (cs[0] = NEXT). Required: uaddr 0, 1, 5, 9.
- **Branch.** cs[2] = BRANCH with csel = 1 and naddr = 12. With cond = 4'b0010, uaddr 2 goes to 12. With cond = 4'b0000, uaddr 2 goes to 3.
- **Call/return and overflow.** STACK_DEPTH = 2:
  - CALL at 1 to 8, CALL at 8 to 16, RET at 16 to 9, RET at 9 to 2.
  - A third nested CALL goes to uaddr 0 with stack_err = 1.
  - RET on an empty stack goes to 0 with stack_err = 1.
- **Reset mid-call.** After one CALL (sp = 1), pulse rst_n low between clock edges. Required: uaddr = 0, ctrl = 0 and stack_err = 0 immediately. A subsequent RET underflows, setting stack_err.
- **Write-while-executing.** While uPC = 4 and unstalled, write cs[4] with a new ctrl. Required: the old ctrl is shown this cycle, and the new value appears the next time uPC = 4.
